// File: rtl/spi_pkg.sv
// Shared types for the SPI register bank: FSM state encoding and R/W command bit values.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/spi_reg_bank_if.sv
// SPI target-side pin bundle; the host drives nCS/SCLK/COPI and the bank drives CIPO.
interface spi_reg_bank_if;
    logic nCS;
    logic SCLK;
    logic COPI;
    logic CIPO;

    modport master (output nCS, output SCLK, output COPI, input CIPO);
    modport slave  (input nCS, input SCLK, input COPI, output CIPO);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module spi_sync_edge #(
    parameter logic IDLE_LVL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= IDLE_LVL;
            sync_q <= IDLE_LVL;
            prev_q <= IDLE_LVL;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign dout = sync_q;
    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target exposing NUM_REGS registers with burst auto-increment for reads and writes.
//   state   | meaning
//   IDLE    | waiting for nCS to fall
//   CMD     | shifting in the R/W bit and address
//   DATA    | shifting data words in (write) or out (read)
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 5,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    spi_reg_bank_if.slave              spi,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr
);
    localparam int CNT_W = $clog2(ADDR_W + 1);
    localparam int BIT_W = $clog2(DATA_W);

    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic unused_sync;

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(spi.nCS),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );
    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi.SCLK),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync_edge #(.IDLE_LVL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(spi.COPI),
        .dout(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    assign unused_sync = ^{ncs_s, sclk_s, copi_rise, copi_fall};

    spi_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           cmd_cnt_q;
    logic [ADDR_W-1:0]          cmd_sr_q;
    logic                       is_wr_q;
    logic [BIT_W-1:0]           bit_cnt_q;
    logic [DATA_W-2:0]          in_sr_q;
    logic [DATA_W-1:0]          out_sr_q;
    logic [ADDR_W-1:0]          ptr_q;
    logic                       load_q;
    logic [NUM_REGS*DATA_W-1:0] regs_q;
    logic                       wr_strobe_q;
    logic [ADDR_W-1:0]          wr_addr_q;

    logic                       cmd_done;
    logic                       word_done;
    logic [ADDR_W:0]            cmd_full;
    logic [DATA_W-1:0]          word_full;
    logic                       ptr_in_range;
    logic [DATA_W-1:0]          rd_word;

    assign cmd_full     = {cmd_sr_q, copi_s};
    assign word_full    = {in_sr_q, copi_s};
    assign ptr_in_range = ({1'b0, ptr_q} < (ADDR_W + 1)'(NUM_REGS));

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr_q == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        cmd_done  = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            ST_IDLE: if (ncs_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (sclk_rise && cmd_cnt_q == CNT_W'(ADDR_W)) begin
                    cmd_done = 1'b1;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: if (sclk_rise && bit_cnt_q == BIT_W'(DATA_W - 1)) word_done = 1'b1;
            default: state_d = ST_IDLE;
        endcase
        // A word completing on the same cycle as nCS release still commits below.
        if (ncs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            is_wr_q     <= 1'b0;
            bit_cnt_q   <= '0;
            in_sr_q     <= '0;
            out_sr_q    <= '0;
            ptr_q       <= '0;
            load_q      <= 1'b0;
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            load_q      <= 1'b0;

            if (state_q == ST_IDLE && ncs_fall) begin
                cmd_cnt_q <= '0;
                cmd_sr_q  <= '0;
                bit_cnt_q <= '0;
                in_sr_q   <= '0;
            end

            if (state_q == ST_CMD && sclk_rise) begin
                cmd_sr_q  <= cmd_full[ADDR_W-1:0];
                cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
            end

            if (cmd_done) begin
                is_wr_q <= (cmd_full[ADDR_W] == RW_WRITE);
                ptr_q   <= cmd_full[ADDR_W-1:0];
                load_q  <= (cmd_full[ADDR_W] == RW_READ);
            end

            if (state_q == ST_DATA && sclk_rise) begin
                in_sr_q   <= word_full[DATA_W-2:0];
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + BIT_W'(1);
            end

            if (word_done) begin
                ptr_q <= ptr_q + ADDR_W'(1);
                if (is_wr_q) begin
                    if (ptr_in_range) begin
                        wr_strobe_q <= 1'b1;
                        wr_addr_q   <= ptr_q;
                    end
                end else begin
                    load_q <= 1'b1;
                end
            end

            for (int i = 0; i < NUM_REGS; i++) begin
                if (word_done && is_wr_q && ptr_q == ADDR_W'(i))
                    regs_q[i*DATA_W +: DATA_W] <= word_full;
            end

            // The falling edge right after a word boundary must not shift away the fresh MSB.
            if (load_q)
                out_sr_q <= rd_word;
            else if (state_q == ST_DATA && sclk_fall && bit_cnt_q != '0)
                out_sr_q <= out_sr_q << 1;
        end
    end

    assign spi.CIPO  = (state_q == ST_DATA && !is_wr_q) ? out_sr_q[DATA_W-1] : 1'b0;
    assign regs_out  = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frames plus random frames against a
// register-array model of the bank.
module tb_spi_reg_bank;
    localparam int NUM_REGS = 5;
    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 7;
    localparam int HALF     = 8;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic                       wr_strobe;
    logic [ADDR_W-1:0]          wr_addr;

    spi_reg_bank_if spi ();

    spi_reg_bank #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .spi(spi),
        .regs_out(regs_out), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mdl_regs [NUM_REGS];
    logic [7:0] frame_q[$];
    logic [7:0] rx_words[$];
    logic [7:0] exp_rd[$];
    int         exp_strobes[$];
    int         got_strobes[$];
    logic       cmd_cipo;

    always @(negedge clk) if (wr_strobe) got_strobes.push_back(int'(wr_addr));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NUM_REGS*DATA_W-1:0] mdl_vec();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[i*DATA_W +: DATA_W] = mdl_regs[i];
        return v;
    endfunction

    // Host side of one frame: sends the first nbits of frame_q, optionally pulsing reset
    // before nCS is released.
    task automatic run_frame(input int nbits, input bit rst_mid);
        logic [7:0] byte_v;
        logic [7:0] rx;
        rx = '0;
        cmd_cipo = 1'b0;
        rx_words.delete();
        got_strobes.delete();
        spi.nCS = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            byte_v = frame_q[i/8];
            spi.COPI = byte_v[7 - (i % 8)];
            repeat (HALF) @(posedge clk);
            @(negedge clk);
            rx = {rx[6:0], spi.CIPO};
            if (i < 8) cmd_cipo = cmd_cipo | spi.CIPO;
            if (i >= 8 && (i % 8) == 7) rx_words.push_back(rx);
            spi.SCLK = 1'b1;
            repeat (HALF) @(posedge clk);
            spi.SCLK = 1'b0;
        end
        if (rst_mid) begin
            @(negedge clk) rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (HALF) @(posedge clk);
        spi.nCS  = 1'b1;
        spi.COPI = 1'b0;
        repeat (2 * HALF) @(posedge clk);
        @(negedge clk);
    endtask

    // Frame-level model: one command byte, then whole words only; partial words vanish.
    task automatic model_frame(input int nbits);
        logic wr;
        int   addr;
        int   nwords;
        exp_strobes.delete();
        exp_rd.delete();
        if (nbits < 8) return;
        wr     = frame_q[0][7];
        addr   = int'(frame_q[0][6:0]);
        nwords = (nbits - 8) / 8;
        for (int k = 0; k < nwords; k++) begin
            if (wr) begin
                exp_rd.push_back(8'h00);
                if (addr < NUM_REGS) begin
                    mdl_regs[addr] = frame_q[k+1];
                    exp_strobes.push_back(addr);
                end
            end else begin
                exp_rd.push_back(addr < NUM_REGS ? mdl_regs[addr] : 8'h00);
            end
            addr = (addr + 1) % (1 << ADDR_W);
        end
    endtask

    task automatic check_frame(input string tag);
        chk({tag, ".regs"}, 64'(regs_out), 64'(mdl_vec()));
        chk({tag, ".strobes"}, 64'(got_strobes.size()), 64'(exp_strobes.size()));
        for (int i = 0; i < exp_strobes.size() && i < got_strobes.size(); i++)
            chk({tag, ".wr_addr"}, 64'(got_strobes[i]), 64'(exp_strobes[i]));
        chk({tag, ".words"}, 64'(rx_words.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rx_words.size(); i++)
            chk({tag, ".cipo_word"}, 64'(rx_words[i]), 64'(exp_rd[i]));
        chk({tag, ".cipo_cmd"}, 64'(cmd_cipo), 64'(0));
        chk({tag, ".cipo_idle"}, 64'(spi.CIPO), 64'(0));
    endtask

    task automatic do_frame(input string tag, input int nbits);
        model_frame(nbits);
        run_frame(nbits, 1'b0);
        check_frame(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       rw;
        logic [6:0] addr;
        int         nwords;
        int         nbits;

        spi.nCS  = 1'b1;
        spi.SCLK = 1'b0;
        spi.COPI = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = 8'h00;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("reset.regs", 64'(regs_out), 64'(0));
        chk("reset.wr_strobe", 64'(wr_strobe), 64'(0));
        chk("reset.wr_addr", 64'(wr_addr), 64'(0));
        chk("reset.cipo", 64'(spi.CIPO), 64'(0));

        frame_q = '{8'h80, 8'hF0};
        do_frame("wr_single", 16);
        chk("wr_single.reg0", 64'(regs_out[7:0]), 64'h0F0);

        frame_q = '{8'h82, 8'hA5};
        do_frame("wr_reg2", 16);
        frame_q = '{8'h02, 8'h00, 8'h00};
        do_frame("rd_reg2", 24);
        chk("rd_reg2.first", 64'(rx_words.size() > 0 ? rx_words[0] : 8'hxx), 64'hA5);

        frame_q = '{8'h83, 8'h11, 8'h22, 8'h33};
        do_frame("wr_burst", 32);
        chk("wr_burst.reg3", 64'(regs_out[31:24]), 64'h11);
        chk("wr_burst.reg4", 64'(regs_out[39:32]), 64'h22);

        frame_q = '{8'h81, 8'hC3};
        do_frame("wr_partial", 12);
        frame_q = '{8'h85, 8'h77};
        do_frame("wr_oob", 16);
        frame_q = '{8'h7F, 8'h00, 8'h00};
        do_frame("rd_wrap", 24);

        for (int n = 0; n < 40; n++) begin
            frame_q.delete();
            rw = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       addr = 7'($urandom_range(0, NUM_REGS - 1));
                1:       addr = 7'($urandom_range(0, 7));
                2:       addr = 7'(126 + $urandom_range(0, 1));
                default: addr = 7'($urandom_range(0, 127));
            endcase
            nwords = $urandom_range(0, 3);
            frame_q.push_back({rw, addr});
            for (int k = 0; k <= nwords; k++) frame_q.push_back(8'($urandom));
            nbits = 8 + 8 * nwords;
            if ($urandom_range(0, 3) == 0) nbits = nbits + $urandom_range(1, 7);
            if ($urandom_range(0, 9) == 0) nbits = $urandom_range(1, 7);
            do_frame("random", nbits);
        end

        frame_q = '{8'h80, 8'h55};
        run_frame(10, 1'b1);
        for (int i = 0; i < NUM_REGS; i++) mdl_regs[i] = 8'h00;
        chk("rst_mid.regs", 64'(regs_out), 64'(0));
        chk("rst_mid.strobes", 64'(got_strobes.size()), 64'(0));
        chk("rst_mid.wr_strobe", 64'(wr_strobe), 64'(0));
        chk("rst_mid.wr_addr", 64'(wr_addr), 64'(0));
        chk("rst_mid.cipo", 64'(spi.CIPO), 64'(0));
        do_frame("after_rst", 16);
        chk("after_rst.reg0", 64'(regs_out[7:0]), 64'h55);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/spi_reg_bank.md
SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 5: number of writable/readable registers, 1..2**ADDR_W.
REQ-002 Parameter DATA_W, default 8: register and data-word width in bits, 8..32.
REQ-003 Parameter ADDR_W, default 7: address field width in bits.
REQ-004 Port clk  input  1: single system clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, synchronous and active-low.
REQ-006 Port nCS  input  1: SPI chip select, active-low, asynchronous to clk.
REQ-007 Port SCLK  input  1: SPI clock, mode 0, asynchronous to clk.
REQ-008 Port COPI  input  1: serial data in, MSB first.
REQ-009 Port CIPO  output  1: serial read data out, MSB first.
REQ-010 Port regs_out  output  NUM_REGS*DATA_W: flattened registers; register i occupies bits [i*DATA_W +: DATA_W].
REQ-011 Port wr_strobe  output  1: one-cycle pulse on each committed register write.
REQ-012 Port wr_addr  output  ADDR_W: address of the write flagged by wr_strobe.

Function
REQ-013 nCS, SCLK and COPI SHALL each pass through a 2-flop synchroniser; SCLK rising and falling edges and nCS edges SHALL be detected on the synchronised signals.
REQ-014 SCLK high and low phases SHALL each be at least 4 clk periods; faster SCLK is out of scope.
REQ-015 Frame format: 1 R/W bit (1 = write), ADDR_W address bits, then one or more DATA_W-bit data words.
REQ-016 FSM states are IDLE, CMD and DATA; synchronised nCS falling edge moves IDLE to CMD and clears all bit counters.
REQ-017 In CMD and DATA, one COPI bit SHALL be shifted in per synchronised SCLK rising edge.
REQ-018 CMD SHALL move to DATA on the rising edge that captures the last address bit; the address is latched into an address pointer.
REQ-019 In a write frame, each completed data word to an address below NUM_REGS SHALL update that register in the clk cycle after the completing edge is detected, with wr_strobe=1 and wr_addr=pointer in the same cycle.
REQ-020 Writes to address >= NUM_REGS SHALL be discarded with no wr_strobe; the frame continues.
REQ-021 After each completed data word, the pointer SHALL increment by 1, wrapping modulo 2**ADDR_W (burst auto-increment).
REQ-022 In a read frame, the out-shifter SHALL load the register at the pointer (0 if pointer >= NUM_REGS) in the cycle after the CMD->DATA transition and after each completed word; CIPO = out-shifter MSB.
REQ-023 The out-shifter SHALL shift left on a synchronised SCLK falling edge only when the in-word bit counter is non-zero.
REQ-024 CIPO SHALL be 0 whenever the FSM is not in DATA of a read frame.
REQ-025 Synchronised nCS rising edge in any state SHALL return the FSM to IDLE; a partial command or data word is discarded with no register change.
REQ-026 An nCS rising edge detected in the same cycle as a word-completing SCLK edge: the word completes and commits, then the FSM goes to IDLE.
REQ-027 Read frames SHALL never modify registers or pulse wr_strobe.

Reset
REQ-028 While rst_n=0 at a clk edge: FSM=IDLE; counters, pointer and shifters =0; synchroniser flops =idle levels (nCS 1, SCLK 0, COPI 0).
REQ-029 Reset values: regs_out all 0, wr_strobe 0, wr_addr 0, CIPO 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release the block waits for a fresh nCS falling edge.

Structure
REQ-031 Package spi_pkg SHALL hold the FSM state typedef and the R/W bit encoding constants.
REQ-032 Sub-module spi_sync_edge (2-flop synchroniser plus rise/fall pulses) SHALL be instantiated once each for nCS, SCLK and COPI.

Verification (default parameters)
REQ-033 Write frame 0x80,0xF0 -> regs_out[7:0]=0xF0; one wr_strobe pulse with wr_addr=0.
REQ-034 Burst 0x83,0x11,0x22,0x33 -> reg3=0x11, reg4=0x22; address 5 discarded; exactly 2 wr_strobe pulses.
REQ-035 With reg2=0xA5, read frame 0x02 plus 16 SCLKs -> CIPO returns 0xA5 then 0x00 (reg3 at reset value).
REQ-036 Write 0x81 then raise nCS after 12 bits -> reg1 unchanged; no wr_strobe.
REQ-037 Write 0x85,0x77 -> all registers unchanged; no wr_strobe.
REQ-038 rst_n low for 2 clk after 10 bits of write 0x80,0x55 -> all outputs at reset values; the next full frame 0x80,0x55 writes reg0=0x55.
